// File: rtl/full_adder.sv
// Registered WIDTH-bit two's-complement adder with carry-in, carry-out and
// signed-overflow flag, built from a ripple chain of 1-bit full-adder cells.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   a, b, Cin        operands and carry-in, sampled when in_valid=1
//   in_valid         operands valid this cycle
//   sum, Cout        registered sum and unsigned carry out of the MSB
//   overflow         registered signed overflow (carry into MSB ^ carry out)
//   out_valid        one-cycle qualifier for a freshly loaded result

module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

module full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             ovf_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             vld_q;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    fa_cell u_fa (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (c[i]),
      .s_o (s_d[i]),
      .c_o (c[i+1])
    );
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign cout_d = c[WIDTH];
  assign ovf_d  = c[WIDTH-1] ^ c[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q  <= s_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum       = sum_q;
  assign Cout      = cout_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: driver pushes hand-computed results,
// monitor pops and compares whenever out_valid is seen.

module tb_full_adder;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       Cin;
  logic       in_valid;
  logic [7:0] sum;
  logic       Cout;
  logic       overflow;
  logic       out_valid;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  full_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .Cout      (Cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8:0] act,
                     input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic [7:0] es,
                       input logic eco, input logic eov);
    exp_t e;
    @(posedge clk);
    #1;
    a        = ia;
    b        = ib;
    Cin      = ic;
    in_valid = 1'b1;
    e.s  = es;
    e.co = eco;
    e.ov = eov;
    q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got sum=0x%0h, want no result",
                   sum);
        end else begin
          e = q.pop_front();
          chk("sum", {1'b0, sum}, {1'b0, e.s});
          chk("Cout", {8'b0, Cout}, {8'b0, e.co});
          chk("overflow", {8'b0, overflow}, {8'b0, e.ov});
        end
      end
    end
  end

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    Cin      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", {1'b0, sum}, 9'h000);
    chk("rst_cout", {8'b0, Cout}, 9'h000);
    chk("rst_ovf", {8'b0, overflow}, 9'h000);
    chk("rst_valid", {8'b0, out_valid}, 9'h000);
    rst = 1'b0;

    issue(8'd12, 8'd17, 1'b0, 8'd29, 1'b0, 1'b0);
    // Positive overflow
    issue(8'd127, 8'd0, 1'b1, 8'h80, 1'b0, 1'b1);
    issue(8'd100, 8'd97, 1'b1, 8'hC6, 1'b0, 1'b1);
    issue(8'd43, 8'd93, 1'b1, 8'h89, 1'b0, 1'b1);
    // Negative overflow with carry
    issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    issue(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
    issue(8'hDA, 8'h95, 1'b0, 8'h6F, 1'b1, 1'b1);
    // Mixed sign
    issue(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0, 1'b0);
    issue(8'd77, 8'hB3, 1'b1, 8'h01, 1'b1, 1'b0);
    issue(8'd100, 8'hBA, 1'b1, 8'h1F, 1'b1, 1'b0);
    issue(8'h9C, 8'd70, 1'b0, 8'hE2, 1'b0, 1'b0);
    idle();
    idle();

    // Streaming then hold
    issue(8'd54, 8'd91, 1'b1, 8'h92, 1'b0, 1'b1);
    issue(8'hCA, 8'hA5, 1'b1, 8'h70, 1'b1, 1'b1);
    issue(8'd0, 8'd0, 1'b1, 8'h01, 1'b0, 1'b0);
    idle();
    @(posedge clk);
    @(negedge clk);
    chk("hold_valid", {8'b0, out_valid}, 9'h000);
    chk("hold_sum", {1'b0, sum}, 9'h001);
    chk("hold_cout", {8'b0, Cout}, 9'h000);
    chk("hold_ovf", {8'b0, overflow}, 9'h000);

    // Reset priority over in_valid
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'd45;
    b        = 8'd21;
    Cin      = 1'b1;
    @(posedge clk);
    #1;
    chk("prio_sum", {1'b0, sum}, 9'h000);
    chk("prio_valid", {8'b0, out_valid}, 9'h000);
    chk("prio_ovf", {8'b0, overflow}, 9'h000);
    rst = 1'b0;
    begin
      exp_t e;
      e.s  = 8'd67;
      e.co = 1'b0;
      e.ov = 1'b0;
      q.push_back(e);
    end
    idle();

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", {1'b0, 8'(q.size())}, 9'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
